wload_ctrl: RTL and testbench
=============================

Name: wload_ctrl

Overview:
- Weight-preload controller: the writer end of the horizontal wreg buffer chain in the ugemmrate 16-bit systolic array.
- Takes weight words from an upstream valid/ready stream.
- Drives the shared en/clr/data bus of a DEPTH-stage wreg chain: clears the chain, shifts exactly DEPTH words in, then signals completion.
- All bus outputs are flop-driven, so they can fan out along a row without extra timing risk.

Parameters:
WIDTH, 16, weight word width; must equal the wreg WIDTH.
DEPTH, 8, number of wreg stages in the chain (words per load); DEPTH >= 1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
i_start  input  1  begin a load; sampled in IDLE only.
i_abort  input  1  cancel any load and clear the chain.
i_valid  input  1  upstream word valid.
o_ready  output  1  upstream ready: (state==LOAD) & ~i_abort.
i_data  input  WIDTH  upstream weight word.
o_en  output  1  wreg chain enable (registered).
o_clr  output  1  wreg chain clear (registered).
o_data  output  WIDTH  wreg chain data (registered).
o_busy  output  1  high when state != IDLE.
o_done  output  1  one-cycle pulse after the last word is written (registered).

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, o_en=0, o_clr=0, o_data=0, o_done=0. o_busy=0 and o_ready=0 follow from state.
- States: IDLE, LOAD, DONE. Encoding lives in the package.
- Accept: state==LOAD & i_valid & o_ready.
- IDLE:
  - i_start & ~i_abort: at the edge, state<=LOAD, cnt<=0, o_clr<=1.
  - Result: o_clr is high during the first LOAD cycle, and o_ready is already high in that cycle.
- LOAD:
  - On accept: o_data<=i_data, o_en<=1, cnt<=cnt+1.
  - If cnt==DEPTH-1 on that accept: state<=DONE.
  - No accept: o_en<=0 and o_data holds. Bubbles are allowed and stall the chain.
- DONE (exactly one cycle): o_en<=0, o_done<=1, state<=IDLE.
  - Result: o_done is high in the cycle after the last o_en, while state is already IDLE.
- o_clr and o_done are single-cycle pulses. Their default next value is 0 every cycle.
- Latency: accepted word k appears on o_data with o_en=1 in the cycle after its accept edge.
  - The first accepted word ends in the deepest stage; word DEPTH-1 ends in stage 0.
- Abort:
  - i_abort=1 in any state: at the edge, state<=IDLE, cnt<=0, o_en<=0, o_clr<=1; o_done stays 0.
  - Abort dominates start and accept. A word presented with i_abort=1 is not consumed, because o_ready is 0 that cycle.
- i_start while state != IDLE: ignored.
- Counter: width $clog2(DEPTH+1). It never exceeds DEPTH-1 while in LOAD. No wrap-around is possible.
- DEPTH=1: the first accept goes straight to DONE.
- Reset mid-load: all outputs return to reset values immediately (async). No o_done is produced.

Decomposition:
- Package wload_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, DONE} wload_state_t;
  - function cnt_w(depth) returning $clog2(depth+1).
- No sub-module. FSM, counter and output flops stay in one always_ff.
- Bench instantiates wload_ctrl driving a DEPTH-stage chain of wreg (en=o_en, clr=o_clr) as its scoreboard model.

Test Plan:
1. Basic load (DEPTH=4, WIDTH=16): start, then valid held high with 0x0011,0x0022,0x0033,0x0044 -> o_clr high in cycle 1; o_en high cycles 2-5; o_done in cycle 6; chain stage3..0 = 0x0011,0x0022,0x0033,0x0044; o_busy low from cycle 6.
2. Bubbles: same data with i_valid low for 2 cycles between words 2 and 3 -> o_en low for exactly those 2 cycles; final chain identical to test 1; o_done 2 cycles later than in test 1.
3. Abort mid-load: abort asserted with i_valid=1 after 2 accepts -> o_ready=0 that cycle; next cycle o_clr=1, o_en=0, state IDLE, o_done never pulses; chain all zero afterwards.
4. Start while busy: i_start pulsed during LOAD and during DONE -> no effect; exactly 4 o_en pulses and one o_done.
5. Async reset mid-load: rst raised between clock edges after 1 accept -> o_en, o_clr, o_done, o_data go to 0 and o_busy goes to 0 before the next edge; a new start after reset performs a clean full load.
6. DEPTH=1 and back-to-back loads: start, one word 0xBEEF -> o_en one cycle, o_done next cycle; start in the o_done cycle is accepted (state is IDLE) and produces o_clr in the following cycle.

Source files
------------

// File: rtl/wload_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wload_pkg
// Brief    : State encoding and sizing helper for the weight-preload controller.
// Revision : 1.0
// ============================================================================
package wload_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wload_state_t;

    // Counter width able to hold 0..depth
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wload_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wload_ctrl
// Brief    : Writer end of the wreg chain: clears it, shifts DEPTH words in,
//            then pulses done. All chain-bus outputs come straight from flops.
// Revision : 1.0
// ============================================================================
module wload_ctrl
    import wload_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_en,
    output logic             o_clr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy,
    output logic             o_done
);

    localparam int               c_CNT_W = cnt_w(DEPTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEPTH - 1);

    wload_state_t         r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_en;
    logic                 r_clr;
    logic [WIDTH-1:0]     r_data;
    logic                 r_done;

    wload_state_t         w_state;
    logic [c_CNT_W-1:0]   w_cnt;
    logic                 w_en;
    logic                 w_clr;
    logic [WIDTH-1:0]     w_data;
    logic                 w_done;
    logic                 w_accept;

    assign o_ready  = (r_state == LOAD) & ~i_abort;
    assign o_busy   = (r_state != IDLE);
    assign w_accept = (r_state == LOAD) & i_valid & o_ready;

    assign o_en   = r_en;
    assign o_clr  = r_clr;
    assign o_data = r_data;
    assign o_done = r_done;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_en    = 1'b0;
        w_clr   = 1'b0;
        w_data  = r_data;
        w_done  = 1'b0;

        // Abort overrides start and accept in every state
        if (i_abort) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_clr   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_state = LOAD;
                        w_cnt   = '0;
                        w_clr   = 1'b1;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        w_data = i_data;
                        w_en   = 1'b1;
                        w_cnt  = r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_LAST) begin
                            w_state = DONE;
                        end
                    end
                end
                DONE: begin
                    w_done  = 1'b1;
                    w_state = IDLE;
                end
                default: begin
                    w_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_en    <= w_en;
            r_clr   <= w_clr;
            r_data  <= w_data;
            r_done  <= w_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wload_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wload_ctrl
// Brief    : Bench for wload_ctrl (DEPTH=4 and DEPTH=1) with a wreg chain model.
// Revision : 1.0
// ============================================================================
module tb_wload_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // DEPTH=4 instance
    logic        s4_start = 0, s4_abort = 0, s4_valid = 0;
    logic [15:0] s4_data  = 0;
    logic        o_ready4, o_en4, o_clr4, o_busy4, o_done4;
    logic [15:0] o_data4;

    // DEPTH=1 instance
    logic        s1_start = 0, s1_abort = 0, s1_valid = 0;
    logic [15:0] s1_data  = 0;
    logic        o_ready1, o_en1, o_clr1, o_busy1, o_done1;
    logic [15:0] o_data1;

    wload_ctrl #(.WIDTH(16), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .i_start(s4_start), .i_abort(s4_abort),
        .i_valid(s4_valid), .o_ready(o_ready4), .i_data(s4_data),
        .o_en(o_en4), .o_clr(o_clr4), .o_data(o_data4),
        .o_busy(o_busy4), .o_done(o_done4)
    );

    wload_ctrl #(.WIDTH(16), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .i_start(s1_start), .i_abort(s1_abort),
        .i_valid(s1_valid), .o_ready(o_ready1), .i_data(s1_data),
        .o_en(o_en1), .o_clr(o_clr1), .o_data(o_data1),
        .o_busy(o_busy1), .o_done(o_done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // wreg chain models: clear wins, enable shifts toward the deepest stage
    logic [15:0] ch4 [4];
    logic [15:0] ch1 [1];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) ch4[i] <= '0;
            ch1[0] <= '0;
        end else begin
            if (o_clr4) begin
                for (int i = 0; i < 4; i++) ch4[i] <= '0;
            end else if (o_en4) begin
                ch4[0] <= o_data4;
                for (int i = 1; i < 4; i++) ch4[i] <= ch4[i-1];
            end
            if (o_clr1)     ch1[0] <= '0;
            else if (o_en1) ch1[0] <= o_data1;
        end
    end

    // Scoreboard: push on handshake, pop when the word reaches the chain bus
    logic [15:0] q4[$];
    logic [15:0] q1[$];
    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
            q1.delete();
        end else begin
            if (o_en4) begin
                if (q4.size() == 0) check("sb4_unexpected_en", 1, 0);
                else                check("sb4_data", o_data4, q4.pop_front());
            end
            if (o_en1) begin
                if (q1.size() == 0) check("sb1_unexpected_en", 1, 0);
                else                check("sb1_data", o_data1, q1.pop_front());
            end
            if (s4_valid && o_ready4) q4.push_back(s4_data);
            if (s1_valid && o_ready1) q1.push_back(s1_data);
        end
    end

    logic [15:0] words [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_chain4(input string tag, input logic [15:0] s3, input logic [15:0] s2,
                              input logic [15:0] s1, input logic [15:0] s0);
        check({tag, "_s3"}, ch4[3], s3);
        check({tag, "_s2"}, ch4[2], s2);
        check({tag, "_s1"}, ch4[1], s1);
        check({tag, "_s0"}, ch4[0], s0);
    endtask

    // Full DEPTH=4 load with an optional bubble before word 2 and start pokes while busy
    task automatic do_load4(input string tag, input int bub_len, input bit poke, input int exp_done);
        int idx, bub, en_cnt, done_cnt, done_cyc;
        idx = 0; bub = 0; en_cnt = 0; done_cnt = 0; done_cyc = 0;
        s4_start = 1;
        tick;
        s4_start = 0;
        check({tag, "_clr_c1"}, o_clr4, 1);
        check({tag, "_ready_c1"}, o_ready4, 1);
        check({tag, "_en_c1"}, o_en4, 0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (o_en4) en_cnt++;
            if (o_done4) begin
                done_cnt++;
                done_cyc = cyc;
                check({tag, "_busy_at_done"}, o_busy4, 0);
            end
            s4_start = poke && o_busy4 && (cyc == 3 || !o_ready4);
            if (idx < 4 && o_ready4) begin
                if (idx == 2 && bub < bub_len) begin
                    s4_valid = 0;
                    bub++;
                end else begin
                    s4_valid = 1;
                    s4_data  = words[idx];
                    idx++;
                end
            end else begin
                s4_valid = 0;
            end
            tick;
        end
        s4_start = 0;
        s4_valid = 0;
        check({tag, "_en_count"}, en_cnt, 4);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        chk_chain4({tag, "_chain"}, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    endtask

    initial begin
        int done_seen;
        tick;
        tick;
        check("rst_en",    o_en4,    0);
        check("rst_clr",   o_clr4,   0);
        check("rst_data",  o_data4,  0);
        check("rst_done",  o_done4,  0);
        check("rst_busy",  o_busy4,  0);
        check("rst_ready", o_ready4, 0);
        rst = 0;
        tick;

        // Basic load, bubbles, start pokes while busy
        do_load4("basic", 0, 0, 6);
        do_load4("bubble", 2, 0, 8);
        do_load4("startbusy", 0, 1, 6);

        // Abort after two accepts with a word presented
        s4_start = 1; tick; s4_start = 0;
        s4_valid = 1; s4_data = 16'h00A1; tick;
        s4_data = 16'h00A2; tick;
        s4_data = 16'h00A3; s4_abort = 1;
        #1;
        check("abort_ready", o_ready4, 0);
        tick;
        s4_abort = 0; s4_valid = 0;
        check("abort_clr",  o_clr4,  1);
        check("abort_en",   o_en4,   0);
        check("abort_busy", o_busy4, 0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_done4) done_seen++;
            tick;
        end
        check("abort_no_done", done_seen, 0);
        chk_chain4("abort_chain", 0, 0, 0, 0);

        // Asynchronous reset after one accept
        s4_start = 1; tick; s4_start = 0;
        s4_valid = 1; s4_data = 16'h0055; tick;
        s4_valid = 0;
        check("pre_rst_en", o_en4, 1);
        #6;
        rst = 1;
        #1;
        check("arst_en",   o_en4,   0);
        check("arst_clr",  o_clr4,  0);
        check("arst_done", o_done4, 0);
        check("arst_data", o_data4, 0);
        check("arst_busy", o_busy4, 0);
        #1;
        rst = 0;
        tick;
        do_load4("postrst", 0, 0, 6);

        // DEPTH=1 with back-to-back loads
        s1_start = 1; tick; s1_start = 0;
        check("d1_clr", o_clr1, 1);
        s1_valid = 1; s1_data = 16'hBEEF; tick;
        s1_valid = 0;
        check("d1_en",   o_en1,   1);
        check("d1_data", o_data1, 16'hBEEF);
        tick;
        check("d1_done", o_done1, 1);
        check("d1_busy", o_busy1, 0);
        check("d1_en_off", o_en1, 0);
        check("d1_chain_a", ch1[0], 16'hBEEF);
        s1_start = 1; tick; s1_start = 0;
        check("d1_b2b_clr",  o_clr1,  1);
        check("d1_b2b_done", o_done1, 0);
        check("d1_b2b_busy", o_busy1, 1);
        s1_valid = 1; s1_data = 16'h1234; tick;
        s1_valid = 0;
        check("d1_b2b_en", o_en1, 1);
        tick;
        check("d1_b2b_done2", o_done1, 1);
        tick;
        check("d1_chain_b", ch1[0], 16'h1234);

        check("q4_empty", q4.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
